rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 8 x 8-bit register file (RF, r0 hard-wired to zero, one write port, two read ports). It shares the single RF write port between two write-back sources: A (ALU) and B (load unit). Each source has a valid/ready handshake and a one-entry holding buffer, and the sources are served round-robin. A per-register pending bitmap gives the issue stage a read-after-write hazard flag for both RF read addresses.

## Interface
- DATA_W, 8, data width; must match RF
- NREG, 8, register count; address width = log2(NREG) = 3
- clk  in  1  rising-edge clock, sole clock
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  source A write request
- a_ready  out  1  source A may hand over this cycle
- a_addr  in  3  source A destination register
- a_data  in  8  source A write data
- b_valid, b_ready, b_addr, b_data  same as A, for source B
- rf_w_en  out  1  registered; drives RF write enable
- rf_w_addr  out  3  registered; drives RF write address
- rf_w_data  out  8  registered; drives RF write data
- pend_set  in  1  issue stage marks a destination as pending
- pend_addr  in  3  register being marked
- rd_addr_0, rd_addr_1  in  3  RF read addresses to check
- hazard_0, hazard_1  out  1  combinational; the read address has a pending write
- pending  out  8  registered pending bitmap; bit i is register i

## Operation
- Holding buffers: buf_a and buf_b, each with a full flag, address and data.
- Grant is combinational from registered state only:
  - Only one buffer full: that buffer is granted.
  - Both full: the buffer not granted last time is granted (last_grant register).
  - Neither full: no grant.
- Grant effect at the clock edge: rf_w_en is loaded with 1, and rf_w_addr/rf_w_data are loaded from the granted buffer. That buffer's full flag clears and last_grant is updated.
- No grant at the edge: rf_w_en is loaded with 0. rf_w_addr and rf_w_data hold their values.
- x_ready = ~buf_x_full | grant_x. There is no combinational path from valid to ready.
- Handshake: a transfer happens when x_valid & x_ready at a clock edge.
  - Nonzero address: the buffer loads and full is set. Load has priority over the grant clear in the same cycle.
  - Address 0: the transfer completes but the buffer is not loaded and no RF write is ever produced.
- Scoreboard, at each edge:
  - A clear happens when rf_w_en = 1; it clears pending[rf_w_addr]. This is the same edge at which the RF commits the write.
  - A set happens when pend_set = 1 and pend_addr != 0; it sets pending[pend_addr].
  - Set and clear to the same register in the same cycle: set wins, because a newer producer has been issued.
  - pending[0] is always 0.
- hazard_k = pending[rd_addr_k] (hazard is 0 for address 0).
- Ordering: there is no ordering between A and B. The issue stage must not hold two outstanding writes to the same register across sources.

## Timing
- Reset (synchronous, at the edge with rst = 1):
  - buf_a and buf_b empty, so a_ready = b_ready = 1 after reset.
  - rf_w_en = 0, rf_w_addr = 0, rf_w_data = 0.
  - pending = 0, so hazard_0 = hazard_1 = 0.
  - last_grant = B, so A is favoured first.
- Reset mid-operation discards buffered writes. Their pending bits are also cleared.
- Latency, with a transfer at edge t:
  - rf_w_en is high during the cycle after edge t+1.
  - The RF write and the pending clear both happen at edge t+2.
- Throughput:
  - A lone source sustains 1 write per cycle, because ready stays high while its buffer is being granted.
  - With both sources streaming, each gets 1 write every 2 cycles, alternating A, B, A, B.
- rst has priority over all other inputs.

## Test plan
- Reset: drive rst for 1 cycle with traffic active. Next cycle: a_ready = b_ready = 1, rf_w_en = 0, pending = 0x00, and a subsequent readback of r0..r7 through the RF shows no new writes.
- Single write: pend_set with addr 3, then A transfers addr 3 / data 0x5A at edge t.
  - Required: rf_w_en = 1, rf_w_addr = 3, rf_w_data = 0x5A in cycle t+1..t+2.
  - With rd_addr_0 = 3: hazard_0 = 1 until edge t+2, then 0 with pending[3] = 0.
  - RF then reads 0x5A from r3.
- Contention: A (r1 = 0x11, r2 = 0x22) and B (r5 = 0x55, r6 = 0x66) valid continuously from reset.
  - Required: RF write order r1, r5, r2, r6, one write per cycle.
  - a_ready and b_ready each low every other cycle.
- r0 discard: A transfers addr 0 / data 0xFF.
  - Required: handshake completes, rf_w_en stays 0, and RF r0 reads 0x00.
  - pend_set with addr 0 leaves pending = 0x00.
- Scoreboard race: pending[4] = 1 and its write is presented on rf_w_en while pend_set with addr 4 is asserted in the same cycle.
  - Required: pending[4] = 1 after the edge and hazard_1 = 1 for rd_addr_1 = 4.
- Randomised: 1000 cycles of random valid/addr/data/pend_set checked against a reference model of RF contents and the pending bitmap.
  - Required: final readback of r0..r7 on both read ports matches the model.
  - Required: no write is lost or duplicated.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file: two buffered sources, round-robin,
// plus a pending-write scoreboard that feeds RAW hazard flags to issue.
module rf_wb_arbiter #(
  parameter int DATA_W = 8,
  parameter int NREG = 8,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_w_en,
  output logic [AW-1:0]     rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  input  logic              pend_set,
  input  logic [AW-1:0]     pend_addr,
  input  logic [AW-1:0]     rd_addr_0,
  input  logic [AW-1:0]     rd_addr_1,
  output logic              hazard_0,
  output logic              hazard_1,
  output logic [NREG-1:0]   pending
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  typedef struct packed {
    logic              full;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } wb_buf_t;

  wb_buf_t         buf_a;
  wb_buf_t         buf_b;
  src_t            last_grant;
  logic            grant_a;
  logic            grant_b;
  logic            load_a;
  logic            load_b;
  logic [NREG-1:0] pend_nxt;

  assign grant_a = buf_a.full &
                   (~buf_b.full | (last_grant == SRC_B));
  assign grant_b = buf_b.full &
                   (~buf_a.full | (last_grant == SRC_A));

  // Ready depends only on registered state, never on valid.
  assign a_ready = ~buf_a.full | grant_a;
  assign b_ready = ~buf_b.full | grant_b;

  assign load_a = a_valid & a_ready & (a_addr != '0);
  assign load_b = b_valid & b_ready & (b_addr != '0);

  // A newly issued producer outranks the commit of an older one.
  always_comb begin
    pend_nxt = pending;
    if (rf_w_en)
      pend_nxt[rf_w_addr] = 1'b0;
    if (pend_set && (pend_addr != '0))
      pend_nxt[pend_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  assign hazard_0 = pending[rd_addr_0];
  assign hazard_1 = pending[rd_addr_1];

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_a      <= '0;
      buf_b      <= '0;
      last_grant <= SRC_B;
      rf_w_en    <= 1'b0;
      rf_w_addr  <= '0;
      rf_w_data  <= '0;
      pending    <= '0;
    end else begin
      unique case (1'b1)
        grant_a: begin
          rf_w_en    <= 1'b1;
          rf_w_addr  <= buf_a.addr;
          rf_w_data  <= buf_a.data;
          last_grant <= SRC_A;
        end
        grant_b: begin
          rf_w_en    <= 1'b1;
          rf_w_addr  <= buf_b.addr;
          rf_w_data  <= buf_b.data;
          last_grant <= SRC_B;
        end
        default: rf_w_en <= 1'b0;
      endcase

      if (load_a)
        buf_a <= '{full: 1'b1, addr: a_addr, data: a_data};
      else if (grant_a)
        buf_a.full <= 1'b0;

      if (load_b)
        buf_b <= '{full: 1'b1, addr: b_addr, data: b_data};
      else if (grant_b)
        buf_b.full <= 1'b0;

      pending <= pend_nxt;
    end
  end

endmodule
